// File: rtl/fmul_pipe.sv
// Three-stage valid/ready floating-point multiplier, bfloat16 by default.
// Round-to-nearest-even, flush-to-zero on subnormal inputs and outputs, Inf/NaN handling.
module fmul_pipe #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 7,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;

    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic [W-1:0]          QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [XW-1:0]  BIAS_X   = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0]  EMAX_X   = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0]  ONE_X    = XW'(1);
    localparam logic signed [XW-1:0]  ZERO_X   = '0;

    function automatic logic [MAN_W:0] rne_round(
        input logic [MAN_W-1:0] man,
        input logic             guard,
        input logic             sticky
    );
        logic up;
        up = guard & (sticky | man[0]);
        return {1'b0, man} + {{MAN_W{1'b0}}, up};
    endfunction

    // Returns {flags, packed result}; out-of-range exponents saturate to Inf or flush to zero.
    function automatic logic [W+3:0] saturate(
        input logic                 sign,
        input logic signed [XW-1:0] e,
        input logic [MAN_W-1:0]     man,
        input logic                 inexact
    );
        logic [W+3:0] r;
        if (e >= EMAX_X) begin
            r = {4'b0101, sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (e <= ZERO_X) begin
            r = {4'b0011, sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        end else begin
            r = {3'b000, inexact, sign, e[EXP_W-1:0], man};
        end
        return r;
    endfunction

    logic stall;
    logic vld_p1_q, vld_p2_q, out_valid_q;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (!stall) begin
            vld_p1_q    <= in_valid;
            vld_p2_q    <= vld_p1_q;
            out_valid_q <= vld_p2_q;
        end
    end

    // ---- stage 1: unpack, classify, multiply significands, add exponents ----
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign {sa, ea, ma} = a;
    assign {sb, eb, mb} = b;

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (ma == '0);
    assign b_inf  = (eb == EXP_ONES) && (mb == '0);
    assign a_nan  = (ea == EXP_ONES) && (ma != '0);
    assign b_nan  = (eb == EXP_ONES) && (mb != '0);

    logic                 sign_p1_d;
    logic [PW-1:0]        prod_p1_d;
    logic signed [XW-1:0] exp_p1_d;
    logic                 spec_p1_d;
    logic [W-1:0]         spec_res_p1_d;
    logic [3:0]           spec_flg_p1_d;

    assign sign_p1_d = sa ^ sb;
    assign prod_p1_d = PW'({1'b1, ma}) * PW'({1'b1, mb});
    assign exp_p1_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;

    always_comb begin
        spec_p1_d     = 1'b1;
        spec_res_p1_d = QNAN;
        spec_flg_p1_d = 4'b0000;
        if (a_nan || b_nan) begin
            spec_p1_d = 1'b1;
        end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
            spec_flg_p1_d = 4'b1000;
        end else if (a_inf || b_inf) begin
            spec_res_p1_d = {sign_p1_d, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            spec_res_p1_d = {sign_p1_d, {(W-1){1'b0}}};
        end else begin
            spec_p1_d = 1'b0;
        end
    end

    logic                 sign_p1_q;
    logic [PW-1:0]        prod_p1_q;
    logic signed [XW-1:0] exp_p1_q;
    logic                 spec_p1_q;
    logic [W-1:0]         spec_res_p1_q;
    logic [3:0]           spec_flg_p1_q;

    always_ff @(posedge clk) begin
        if (!stall && in_valid) begin
            sign_p1_q     <= sign_p1_d;
            prod_p1_q     <= prod_p1_d;
            exp_p1_q      <= exp_p1_d;
            spec_p1_q     <= spec_p1_d;
            spec_res_p1_q <= spec_res_p1_d;
            spec_flg_p1_q <= spec_flg_p1_d;
        end
    end

    // ---- stage 2: normalise to a hidden bit, extract kept/guard/sticky ----
    logic [PW-2:0]        norm_p2;
    logic signed [XW-1:0] exp_p2_d;
    logic [MAN_W-1:0]     man_p2_d;
    logic                 guard_p2_d, sticky_p2_d;

    // norm_p2 excludes the hidden bit in both cases
    assign norm_p2     = prod_p1_q[PW-1] ? prod_p1_q[PW-2:0] : {prod_p1_q[PW-3:0], 1'b0};
    assign exp_p2_d    = prod_p1_q[PW-1] ? exp_p1_q + ONE_X : exp_p1_q;
    assign man_p2_d    = norm_p2[PW-2 -: MAN_W];
    assign guard_p2_d  = norm_p2[MAN_W];
    assign sticky_p2_d = |norm_p2[MAN_W-1:0];

    logic                 sign_p2_q;
    logic signed [XW-1:0] exp_p2_q;
    logic [MAN_W-1:0]     man_p2_q;
    logic                 guard_p2_q, sticky_p2_q;
    logic                 spec_p2_q;
    logic [W-1:0]         spec_res_p2_q;
    logic [3:0]           spec_flg_p2_q;

    always_ff @(posedge clk) begin
        if (!stall && vld_p1_q) begin
            sign_p2_q     <= sign_p1_q;
            exp_p2_q      <= exp_p2_d;
            man_p2_q      <= man_p2_d;
            guard_p2_q    <= guard_p2_d;
            sticky_p2_q   <= sticky_p2_d;
            spec_p2_q     <= spec_p1_q;
            spec_res_p2_q <= spec_res_p1_q;
            spec_flg_p2_q <= spec_flg_p1_q;
        end
    end

    // ---- stage 3: round, range-check, select special result, register output ----
    logic [MAN_W:0]       rnd_p3;
    logic signed [XW-1:0] exp_p3;
    logic [W-1:0]         result_p3_d;
    logic [3:0]           flags_p3_d;

    assign rnd_p3 = rne_round(man_p2_q, guard_p2_q, sticky_p2_q);
    assign exp_p3 = rnd_p3[MAN_W] ? exp_p2_q + ONE_X : exp_p2_q;
    assign {flags_p3_d, result_p3_d} = spec_p2_q
        ? {spec_flg_p2_q, spec_res_p2_q}
        : saturate(sign_p2_q, exp_p3, rnd_p3[MAN_W-1:0], guard_p2_q | sticky_p2_q);

    logic [W-1:0] result_q;
    logic [3:0]   flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (!stall && vld_p2_q) begin
            result_q <= result_p3_d;
            flags_q  <= flags_p3_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe (bf16): directed vector table, stall stream, mid-flight reset.
module tb_fmul_pipe;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flg;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          cyc;
        bit          chk_lat;
        int          id;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   stall_cycles = 0;
    exp_t sb[$];
    vec_t vecs[20];

    fmul_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: pops on each output handshake, checks held values while stalled.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else if (out_ready) begin
                e = sb.pop_front();
                check($sformatf("result[%0d]", e.id), 32'(result), 32'(e.res));
                check($sformatf("flags[%0d]", e.id), 32'(flags), 32'(e.flg));
                if (e.chk_lat)
                    check($sformatf("latency[%0d]", e.id), 32'(cyc - e.cyc), 32'd3);
            end else begin
                stall_cycles++;
                check("held_result", 32'(result), 32'(sb[0].res));
                check("held_flags", 32'(flags), 32'(sb[0].flg));
                check("in_ready_stalled", 32'(in_ready), 32'd0);
            end
        end
    end

    task automatic send(input vec_t v, input int id, input bit lat);
        exp_t e;
        int   waited;
        a        = v.a;
        b        = v.b;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 50) check("accept_timeout", 32'(in_ready), 32'd1);
        e.res     = v.res;
        e.flg     = v.flg;
        e.cyc     = cyc;
        e.chk_lat = lat;
        e.id      = id;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs = '{
            '{16'h3F80, 16'h4000, 16'h4000, 4'h0},
            '{16'h3FC0, 16'h3FC0, 16'h4010, 4'h0},
            '{16'h3F81, 16'h3F81, 16'h3F82, 4'h1},
            '{16'h0000, 16'h7F80, 16'h7FC0, 4'h8},
            '{16'hFF80, 16'h4000, 16'hFF80, 4'h0},
            '{16'h7F00, 16'h4000, 16'h7F80, 4'h5},
            '{16'h0080, 16'h3F00, 16'h0000, 4'h3},
            '{16'h0001, 16'h3F80, 16'h0000, 4'h0},
            '{16'h3F81, 16'h3FC0, 16'h3FC2, 4'h1},
            '{16'h3F83, 16'h3FC0, 16'h3FC4, 4'h1},
            '{16'h3FE0, 16'h3F92, 16'h4000, 4'h1},
            '{16'hBFC0, 16'h3FC0, 16'hC010, 4'h0},
            '{16'h0080, 16'h3F80, 16'h0080, 4'h0},
            '{16'h7F7F, 16'h3F80, 16'h7F7F, 4'h0},
            '{16'h7F81, 16'h0000, 16'h7FC0, 4'h0},
            '{16'hFF80, 16'h8000, 16'h7FC0, 4'h8},
            '{16'h7F80, 16'h0001, 16'h7FC0, 4'h8},
            '{16'hFF00, 16'h4000, 16'hFF80, 4'h5},
            '{16'h7F80, 16'hFF80, 16'hFF80, 4'h0},
            '{16'h8000, 16'h4000, 16'h8000, 4'h0}
        };

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", 32'(flags), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table, issued back to back with latency checks
        for (int i = 0; i < 20; i++) send(vecs[i], i, 1'b1);
        in_valid = 1'b0;
        drain();

        // Six-pair stream with out_ready held low for five cycles
        @(posedge clk);
        #1;
        stall_cycles = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(vecs[i], 100 + i, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_cycles", 32'(stall_cycles), 32'd5);

        // Reset pulse with two pairs in flight
        @(posedge clk);
        #1;
        send(vecs[1], 200, 1'b0);
        send(vecs[2], 201, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        repeat (2) begin
            @(negedge clk);
            check("in_reset_out_valid", 32'(out_valid), 32'd0);
            check("in_reset_result", 32'(result), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("post_reset_out_valid", 32'(out_valid), 32'd0);
        end

        // Pipeline still works after reset
        @(posedge clk);
        #1;
        send(vecs[5], 300, 1'b1);
        in_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
